axis_uart: RTL and testbench

8N1 UART bridge between two AXI-Stream byte channels and a pair of serial pins. Bytes accepted on the slave stream are serialized on `uart_tx`. Frames received on `uart_rx` are deserialized and presented on the master stream. The block sits at the edge of the fabric, between the host-side stream logic and the board UART pins.

---
 rtl/axis_uart.sv | 143 ++++++++++++++
 tb/tb_axis_uart.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart.sv
// 8N1 UART bridge: bytes from s_axis are serialized on uart_tx, frames on uart_rx
// are deserialized into a single-entry holding register that drives m_axis.
module axis_uart #(
    parameter int CLOCK     = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready
);

    localparam int BIT_CYCLES = CLOCK / BAUD_RATE;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CNT_W      = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_bit_end;
    logic             tx_accept;

    assign tx_bit_end = (tx_cnt == CNT_LAST);
    assign tx_accept  = s_axis_tvalid && s_axis_tready;

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_accept) tx_state_nxt = TX_START;
            TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    // uart_tx is registered from the current state, so the line lags the FSM by one clock
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_state      <= TX_IDLE;
            tx_cnt        <= '0;
            tx_idx        <= '0;
            uart_tx       <= 1'b1;
            s_axis_tready <= 1'b0;
        end else begin
            tx_state      <= tx_state_nxt;
            s_axis_tready <= (tx_state_nxt == TX_IDLE);
            tx_cnt        <= (tx_state == TX_IDLE || tx_bit_end) ? '0 : tx_cnt + CNT_W'(1);
            if (tx_state == TX_DATA && tx_bit_end)
                tx_idx <= tx_idx + 3'd1;
            case (tx_state)
                TX_START: uart_tx <= 1'b0;
                TX_DATA:  uart_tx <= tx_shift[0];
                default:  uart_tx <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (tx_state == TX_IDLE && tx_accept)
            tx_shift <= s_axis_tdata;
        else if (tx_state == TX_DATA && tx_bit_end)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // sync stage 0 -> 1: metastability guard on the asynchronous serial input
    logic rx_sync_p0, rx_sync_p1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= uart_rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_sample;
    logic             rx_done;

    assign rx_sample = (rx_state == RX_START) ? (rx_cnt == CNT_HALF) : (rx_cnt == CNT_LAST);
    assign rx_done   = (rx_state == RX_STOP) && rx_sample && rx_sync_p1;

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync_p1) rx_state_nxt = RX_START;
            RX_START: if (rx_sample) rx_state_nxt = rx_sync_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_idx == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_sample) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= (rx_state == RX_IDLE || rx_sample) ? '0 : rx_cnt + CNT_W'(1);
            if (rx_state == RX_DATA && rx_sample)
                rx_idx <= rx_idx + 3'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rx_state == RX_DATA && rx_sample)
            rx_shift <= {rx_sync_p1, rx_shift[7:1]};
    end

    // A completed byte is dropped while an unconsumed byte is still held
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (rx_done && (!m_axis_tvalid || m_axis_tready)) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= rx_shift;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_uart.sv
// Scoreboard bench for axis_uart: TX waveform, loopback, RX backpressure,
// framing error, glitch rejection and reset mid-frame.
module tb_axis_uart;

    localparam int CLOCK = 1_600_000;
    localparam int BAUD  = 100_000;
    localparam int BC    = CLOCK / BAUD;
    localparam int HALF  = BC / 2;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       uart_tx;
    logic       uart_rx;
    logic       drv_rx = 1'b1;
    logic       loop_en = 1'b0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;

    int         total = 0;
    int         bad = 0;
    int         rx_cnt = 0;
    int         base;
    logic [7:0] exp_q[$];
    logic [7:0] lb_bytes[6] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h55, 8'hAA};

    assign uart_rx = loop_en ? uart_tx : drv_rx;

    always #5 aclk = ~aclk;

    axis_uart #(.CLOCK(CLOCK), .BAUD_RATE(BAUD)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!s_tready && n < 20 * BC) begin
            step();
            n++;
        end
        chk("tx_ready_wait", 32'(s_tready), 32'd1);
        s_tvalid = 1'b1;
        s_tdata  = b;
        step();
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
    endtask

    task automatic send_check(input logic [7:0] b);
        logic [9:0] frame;
        int low = 0;
        int k;
        frame = {1'b1, b, 1'b0};
        send_byte(b);
        for (int i = 0; i <= 10 * BC; i++) begin
            if (!s_tready) low++;
            if (i == 0) chk("tx_latency", 32'(uart_tx), 32'd1);
            if (i == 1) chk("tx_fall", 32'(uart_tx), 32'd0);
            if (i >= 1 && (i - 1) % BC == HALF && (i - 1) / BC < 10) begin
                k = (i - 1) / BC;
                chk($sformatf("tx_bit%0d", k), 32'(uart_tx), 32'(frame[k]));
            end
            if (i < 10 * BC) step();
        end
        chk("tx_ready_low", 32'(low), 32'(10 * BC));
        chk("tx_ready_back", 32'(s_tready), 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drv_rx = f[k];
            repeat (BC) step();
        end
        drv_rx = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40 * BC) begin
            step();
            n++;
        end
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0)
                chk("rx_unexpected", {24'h0, m_tdata}, 32'h100);
            else
                chk("rx_data", {24'h0, m_tdata}, {24'h0, exp_q.pop_front()});
            rx_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", {24'h0, m_tdata}, 32'd0);
        aresetn = 1'b1;
        chk("tready_pre_edge", 32'(s_tready), 32'd0);
        step();
        chk("tready_post_edge", 32'(s_tready), 32'd1);

        send_check(8'hA5);
        repeat (BC) step();

        loop_en  = 1'b1;
        m_tready = 1'b1;
        base     = rx_cnt;
        foreach (lb_bytes[i]) begin
            exp_q.push_back(lb_bytes[i]);
            send_byte(lb_bytes[i]);
        end
        wait_drain();
        repeat (2 * BC) step();
        chk("lb_count", 32'(rx_cnt - base), 32'd6);
        loop_en = 1'b0;
        repeat (2 * BC) step();

        m_tready = 1'b0;
        base     = rx_cnt;
        drive_frame(8'h3C, 1'b1);
        chk("bp_valid1", 32'(m_tvalid), 32'd1);
        chk("bp_data1", {24'h0, m_tdata}, 32'h3C);
        drive_frame(8'hC3, 1'b1);
        repeat (BC) step();
        chk("bp_valid2", 32'(m_tvalid), 32'd1);
        chk("bp_data2", {24'h0, m_tdata}, 32'h3C);
        exp_q.push_back(8'h3C);
        m_tready = 1'b1;
        step();
        step();
        chk("bp_clear", 32'(m_tvalid), 32'd0);
        chk("bp_count", 32'(rx_cnt - base), 32'd1);

        base = rx_cnt;
        drive_frame(8'h81, 1'b0);
        repeat (3 * BC) step();
        chk("fe_valid", 32'(m_tvalid), 32'd0);
        chk("fe_none", 32'(rx_cnt - base), 32'd0);
        exp_q.push_back(8'h42);
        drive_frame(8'h42, 1'b1);
        wait_drain();
        chk("fe_count", 32'(rx_cnt - base), 32'd1);

        base   = rx_cnt;
        drv_rx = 1'b0;
        repeat (BC / 4) step();
        drv_rx = 1'b1;
        repeat (2 * BC) step();
        chk("gl_valid", 32'(m_tvalid), 32'd0);
        chk("gl_none", 32'(rx_cnt - base), 32'd0);
        exp_q.push_back(8'h7E);
        drive_frame(8'h7E, 1'b1);
        wait_drain();
        chk("gl_count", 32'(rx_cnt - base), 32'd1);

        send_byte(8'hF0);
        repeat (1 + 4 * BC + HALF) step();
        chk("mid_bit3", 32'(uart_tx), 32'd0);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(uart_tx), 32'd1);
        chk("mid_rst_ready", 32'(s_tready), 32'd0);
        step();
        step();
        aresetn = 1'b1;
        step();
        chk("mid_rel_ready", 32'(s_tready), 32'd1);
        send_check(8'h11);
        repeat (BC) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
